pipeline_controller: RTL
========================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum MEM_WAIT cycles before the timeout error.
REQ-002 Parameter DEST_LSU, default 2'b01: data_dest encoding that marks a load result (shared package constant).
REQ-003 Ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high reset.
REQ-004 Ports: id_rs1_addr_i in 5, id_rs2_addr_i in 5, id_rs1_used_i in 1, id_rs2_used_i in 1: decode-stage source operands.
REQ-005 Ports: ex_reg_wr_addr_i in 5, ex_reg_wr_sig_i in 1, ex_data_dest_i in 2: the instruction currently held in ID/EX.
REQ-006 Ports: ex_br_mispred_i in 1, execute-stage branch resolved against its prediction.
REQ-007 Ports: mem_req_i in 1, mem_ack_i in 1: LSU access issued and LSU access completed.
REQ-008 Ports: pc_stall_o out 1, if_id_stall_o out 1, if_id_flush_o out 1, id_ex_stall_o out 1 (bubble insert), id_ex_flush_o out 1, ex_mem_hold_o out 1.
REQ-009 Ports: stall_cnt_o out 32, flush_cnt_o out 16, mem_timeout_o out 1 (sticky).

Function
REQ-010 FSM states SHALL be RUN, MEM_WAIT, FLUSH2.
REQ-011 Load-use hazard SHALL be ex_reg_wr_sig_i & ex_data_dest_i==DEST_LSU & ex_reg_wr_addr_i!=0 & ((id_rs1_used_i & rs1==ex addr) | (id_rs2_used_i & rs2==ex addr)).
REQ-012 In RUN with hazard only: pc_stall_o=1, if_id_stall_o=1, id_ex_stall_o=1, combinationally in the same cycle; one-cycle bubble per hazard instance.
REQ-013 In RUN with ex_br_mispred_i=1: if_id_flush_o=1, id_ex_flush_o=1 same cycle; next state FLUSH2; flush_cnt_o increments.
REQ-014 FLUSH2 SHALL last exactly one cycle asserting if_id_flush_o only, then return to RUN.
REQ-015 In RUN with mem_req_i=1 and mem_ack_i=0: next state MEM_WAIT; mem_req_i with mem_ack_i in the same cycle SHALL cause no stall.
REQ-016 In MEM_WAIT: pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_hold_o all 1; exit to RUN the cycle after mem_ack_i=1.
REQ-017 Priority RUN: mem wait > mispredict > load-use; a mispredict and load-use together SHALL produce flush only.
REQ-018 Mispredict in the cycle entering MEM_WAIT SHALL be latched in a pending flag and issued as the RUN flush on MEM_WAIT exit; pending cleared then.
REQ-019 Wait counter SHALL count MEM_WAIT cycles; on reaching MEM_TIMEOUT, mem_timeout_o sets (sticky until reset) and FSM forces RUN.
REQ-020 stall_cnt_o SHALL increment on every cycle pc_stall_o=1, saturating at 32'hFFFFFFFF; flush_cnt_o saturates at 16'hFFFF.
REQ-021 ex_reg_wr_addr_i==0 SHALL never cause a hazard.

Reset
REQ-022 reset=1 SHALL asynchronously force state RUN, pending=0, wait counter=0, stall_cnt_o=0, flush_cnt_o=0, mem_timeout_o=0.
REQ-023 During reset all stall/flush/hold outputs SHALL be 0; reset mid-MEM_WAIT abandons the wait with no residual stall.

Structure
REQ-024 State encoding, DEST_LSU and counter widths SHALL live in the shared parameters package.
REQ-025 Hazard compare SHALL be a sub-module hazard_detect (pure combinational); FSM and counters in pipeline_controller.

Verification
REQ-026 Load x5 in EX, ID uses rs1=x5 -> one cycle pc/if_id/id_ex stall, stall_cnt_o=1.
REQ-027 Load writing x0, ID rs1=x0 -> no stall.
REQ-028 ex_br_mispred_i pulse -> cycle N both flushes, cycle N+1 if_id_flush_o only, flush_cnt_o=1.
REQ-029 mem_req_i with ack 3 cycles later -> 3 full-hold cycles, then RUN; mispredict at entry -> flush on exit.
REQ-030 mem_req_i, no ack, MEM_TIMEOUT=4 -> 4 hold cycles, mem_timeout_o=1 and stays 1.
REQ-031 reset asserted in MEM_WAIT -> outputs 0 immediately, counters 0.

Source files
------------

// File: rtl/pipeline_controller_pkg.sv
// Shared constants for the pipeline hazard/flush controller: FSM encoding,
// load-destination code and counter widths.
package pipeline_controller_pkg;

   localparam int STATE_W = 2;

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_FLUSH2   = 2'd2;

   localparam logic [1:0] DEST_LSU_DEF = 2'b01;

   localparam int STALL_CNT_W = 32;
   localparam int FLUSH_CNT_W = 16;
   localparam int WAIT_CNT_W  = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the decode-stage sources and the
// instruction currently held in ID/EX. Purely combinational.
module hazard_detect
   import pipeline_controller_pkg::*;
#(
   parameter logic [1:0] DEST_LSU = DEST_LSU_DEF
) (
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   input  logic       id_rs1_used_i,
   input  logic       id_rs2_used_i,
   input  logic [4:0] ex_reg_wr_addr_i,
   input  logic       ex_reg_wr_sig_i,
   input  logic [1:0] ex_data_dest_i,
   output logic       hazard_o
);

   logic ex_is_load;
   logic rs1_match;
   logic rs2_match;

   // x0 is hard-wired zero, so a load targeting it never produces a dependency.
   assign ex_is_load = ex_reg_wr_sig_i && (ex_data_dest_i == DEST_LSU) &&
                       (ex_reg_wr_addr_i != 5'd0);
   assign rs1_match  = id_rs1_used_i && (id_rs1_addr_i == ex_reg_wr_addr_i);
   assign rs2_match  = id_rs2_used_i && (id_rs2_addr_i == ex_reg_wr_addr_i);
   assign hazard_o   = ex_is_load && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: load-use bubbles, mispredict flushes
// (two-cycle) and LSU wait holds with timeout, plus stall/flush statistics.
module pipeline_controller
   import pipeline_controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter logic [1:0]  DEST_LSU    = DEST_LSU_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             id_rs1_addr_i,
   input  logic [4:0]             id_rs2_addr_i,
   input  logic                   id_rs1_used_i,
   input  logic                   id_rs2_used_i,
   input  logic [4:0]             ex_reg_wr_addr_i,
   input  logic                   ex_reg_wr_sig_i,
   input  logic [1:0]             ex_data_dest_i,
   input  logic                   ex_br_mispred_i,
   input  logic                   mem_req_i,
   input  logic                   mem_ack_i,
   output logic                   pc_stall_o,
   output logic                   if_id_stall_o,
   output logic                   if_id_flush_o,
   output logic                   id_ex_stall_o,
   output logic                   id_ex_flush_o,
   output logic                   ex_mem_hold_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o,
   output logic [FLUSH_CNT_W-1:0] flush_cnt_o,
   output logic                   mem_timeout_o
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);

   logic [STATE_W-1:0]     state_q, state_d;
   logic                   pending_q, pending_d;
   logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic                   timeout_q, timeout_d;

   logic hazard, mem_enter, flush_req, timeout_hit;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_hold;

   hazard_detect #(
      .DEST_LSU (DEST_LSU)
   ) u_hazard (
      .id_rs1_addr_i    (id_rs1_addr_i),
      .id_rs2_addr_i    (id_rs2_addr_i),
      .id_rs1_used_i    (id_rs1_used_i),
      .id_rs2_used_i    (id_rs2_used_i),
      .ex_reg_wr_addr_i (ex_reg_wr_addr_i),
      .ex_reg_wr_sig_i  (ex_reg_wr_sig_i),
      .ex_data_dest_i   (ex_data_dest_i),
      .hazard_o         (hazard)
   );

   assign mem_enter   = mem_req_i && !mem_ack_i;
   assign flush_req   = ex_br_mispred_i || pending_q;
   assign timeout_hit = (wait_cnt_q + 1'b1) == TIMEOUT_C;

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_stall = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_hold = 1'b0;
      case (state_q)
         ST_RUN: begin
            // A mispredict seen while entering the wait is deferred, not dropped.
            if (mem_enter) begin
               state_d    = ST_MEM_WAIT;
               pending_d  = pending_q || ex_br_mispred_i;
               wait_cnt_d = '0;
            end else if (flush_req) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               pending_d   = 1'b0;
               state_d     = ST_FLUSH2;
            end else if (hazard) begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_stall = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            ex_mem_hold = 1'b1;
            wait_cnt_d  = wait_cnt_q + 1'b1;
            if (mem_ack_i) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (timeout_hit) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
               timeout_d  = 1'b1;
            end
         end
         ST_FLUSH2: begin
            if_id_flush = 1'b1;
            state_d     = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Outputs are forced low while reset is held, independent of the inputs.
   assign pc_stall_o    = pc_stall    && !reset;
   assign if_id_stall_o = if_id_stall && !reset;
   assign if_id_flush_o = if_id_flush && !reset;
   assign id_ex_stall_o = id_ex_stall && !reset;
   assign id_ex_flush_o = id_ex_flush && !reset;
   assign ex_mem_hold_o = ex_mem_hold && !reset;

   assign stall_cnt_d = (pc_stall_o && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   assign flush_cnt_d = (id_ex_flush_o && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pending_q   <= 1'b0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign stall_cnt_o   = stall_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;
   assign mem_timeout_o = timeout_q;

endmodule
